// File: rtl/flash_thermo_frontend_pkg.sv
// Shared definitions for the flash ADC thermometer front end and the downstream capture logic.
// State encodings are fixed because other blocks decode them directly.
package flash_thermo_frontend_pkg;

  localparam int unsigned N_CMP = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_CORRECT = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StCapture = ST_CAPTURE,
    StCorrect = ST_CORRECT,
    StPresent = ST_PRESENT
  } state_e;

endpackage

// File: rtl/flash_thermo_frontend_if.sv
// Comparator/handshake bundle between the thermometer front end and its environment.
// The front end takes the slave side; the sampling logic (or a bench) takes the master side.
interface flash_thermo_frontend_if;
  import flash_thermo_frontend_pkg::*;

  logic [N_CMP-1:0] cmp_in;
  logic             sample_req;
  logic             sample_busy;
  logic [N_CMP-1:0] I_low;
  logic             En_low;
  logic             code_valid;
  logic             bubble_err;
  logic             overrange;
  logic             underrange;
  logic             req_dropped;

  modport master (
    output cmp_in, sample_req,
    input  sample_busy, I_low, En_low, code_valid, bubble_err, overrange, underrange,
           req_dropped
  );

  modport slave (
    input  cmp_in, sample_req,
    output sample_busy, I_low, En_low, code_valid, bubble_err, overrange, underrange,
           req_dropped
  );

endinterface

// File: rtl/thermo_bubble_fix.sv
// Combinational single-bubble corrector and thermometer-to-one-hot converter.
// Bit -1 is treated as 1 and bit N_CMP as 0, so the code is anchored at both ends.
module thermo_bubble_fix
  import flash_thermo_frontend_pkg::*;
(
  input  logic [N_CMP-1:0] t,
  output logic [N_CMP-1:0] tc,
  output logic [N_CMP-1:0] onehot,
  output logic             err,
  output logic             all0,
  output logic             all1
);

  logic [N_CMP+1:0] t_ext;
  logic [N_CMP:0]   tc_ext;

  assign t_ext  = {1'b0, t, 1'b1};
  assign tc_ext = {1'b0, tc};

  always_comb begin
    tc     = '0;
    onehot = '0;
    for (int i = 0; i < N_CMP; i++) begin
      tc[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) | (t_ext[i+1] & t_ext[i+2]);
    end
    for (int i = 0; i < N_CMP; i++) begin
      onehot[i] = tc_ext[i] & ~tc_ext[i+1];
    end
  end

  assign err  = (tc != t);
  assign all0 = ~|tc;
  assign all1 = &tc;

endmodule

// File: rtl/flash_thermo_frontend.sv
// Synchronises the comparator bank, captures one thermometer code per request, bubble-corrects
// it and presents an active-low one-hot code to the priority encoder under a busy/valid frame.
module flash_thermo_frontend #(
  parameter int unsigned N_CMP       = flash_thermo_frontend_pkg::N_CMP,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    clk,
  input logic                    rst,
  flash_thermo_frontend_if.slave bus
);
  import flash_thermo_frontend_pkg::*;

  logic [SYNC_STAGES-1:0][N_CMP-1:0] sync_q;
  logic [N_CMP-1:0]                  t_sync;
  logic [N_CMP-1:0]                  t_cap_q;
  logic [N_CMP-1:0]                  tc;
  logic [N_CMP-1:0]                  onehot;
  logic                              fix_err, fix_all0, fix_all1;
  logic [N_CMP-1:0]                  i_low_q;
  logic                              bubble_q, over_q, under_q, dropped_q;
  logic                              unused_tc;
  state_e                            state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.cmp_in};
    end
  end

  assign t_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.sample_req) state_d = StCapture;
      StCapture: state_d = StCorrect;
      StCorrect: state_d = StPresent;
      StPresent: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  thermo_bubble_fix u_bubble_fix (
    .t      (t_cap_q),
    .tc     (tc),
    .onehot (onehot),
    .err    (fix_err),
    .all0   (fix_all0),
    .all1   (fix_all1)
  );

  // Outputs and flags change only on the CORRECT edge, so they hold between conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cap_q   <= '0;
      i_low_q   <= '1;
      bubble_q  <= 1'b0;
      over_q    <= 1'b0;
      under_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      if (state_q == StCapture) t_cap_q <= t_sync;
      if (state_q == StCorrect) begin
        i_low_q  <= ~onehot;
        bubble_q <= fix_err;
        over_q   <= fix_all1;
        under_q  <= fix_all0;
      end
      if (bus.sample_req && (state_q != StIdle)) dropped_q <= 1'b1;
    end
  end

  assign unused_tc = ^tc;

  assign bus.sample_busy = (state_q != StIdle);
  assign bus.code_valid  = (state_q == StPresent);
  assign bus.En_low      = (state_q != StPresent);
  assign bus.I_low       = i_low_q;
  assign bus.bubble_err  = bubble_q;
  assign bus.overrange   = over_q;
  assign bus.underrange  = under_q;
  assign bus.req_dropped = dropped_q;

endmodule

// File: tb/tb_flash_thermo_frontend.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops them on code_valid.
module tb_flash_thermo_frontend;

  localparam int unsigned SyncStages = 2;

  logic clk = 1'b0;
  logic rst;
  logic rst_q;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flash_thermo_frontend_if bus ();

  flash_thermo_frontend #(
    .N_CMP       (8),
    .SYNC_STAGES (SyncStages)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] i_low;
    logic       bubble;
    logic       over;
    logic       under;
    logic [2:0] y_low;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic       dropped_exp = 1'b0;
  logic [7:0] last_i_low;
  logic [2:0] last_flags;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic int bit_at(input logic [7:0] t, input int i);
    if (i < 0) return 1;
    if (i > 7) return 0;
    return int'(t[i]);
  endfunction

  // Reference: per-bit neighbour vote, edge detection, and the index the encoder reports.
  function automatic exp_t model(input logic [7:0] t);
    exp_t       r;
    logic [7:0] tc;
    logic [7:0] h;
    int         top;
    top = -1;
    for (int i = 0; i < 8; i++) begin
      tc[i] = ((bit_at(t, i - 1) + bit_at(t, i) + bit_at(t, i + 1)) >= 2);
    end
    for (int i = 0; i < 8; i++) begin
      h[i] = tc[i] && ((i == 7) || !tc[i+1]);
      if (h[i]) top = i;
    end
    r.i_low  = ~h;
    r.bubble = (tc != t);
    r.over   = (tc == 8'hFF);
    r.under  = (tc == 8'h00);
    r.y_low  = (top < 0) ? 3'b111 : ~3'(top);
    r.due    = 0;
    return r;
  endfunction

  // Downstream active-low 8:3 priority encoder, highest line wins.
  function automatic logic [2:0] enc(input logic [7:0] il);
    int idx;
    idx = -1;
    for (int i = 0; i < 8; i++) if (!il[i]) idx = i;
    return (idx < 0) ? 3'b111 : ~3'(idx);
  endfunction

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst_q) begin
        check("rst_i_low", 32'(bus.I_low), 32'hFF);
        check("rst_en_low", 32'(bus.En_low), 32'd1);
        check("rst_valid", 32'(bus.code_valid), 32'd0);
        check("rst_busy", 32'(bus.sample_busy), 32'd0);
        check("rst_flags", 32'({bus.bubble_err, bus.overrange, bus.underrange}), 32'd0);
        check("rst_dropped", 32'(bus.req_dropped), 32'd0);
        last_i_low = 8'hFF;
        last_flags = 3'b000;
      end else begin
        if (bus.code_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid at cycle %0d: got code_valid=1, expected 0", cyc);
          end else begin
            e = exp_q.pop_front();
            check("latency", 32'(cyc), 32'(e.due));
            check("i_low", 32'(bus.I_low), 32'(e.i_low));
            check("bubble_err", 32'(bus.bubble_err), 32'(e.bubble));
            check("overrange", 32'(bus.overrange), 32'(e.over));
            check("underrange", 32'(bus.underrange), 32'(e.under));
            check("y_low", 32'(enc(bus.I_low)), 32'(e.y_low));
            check("en_low_valid", 32'(bus.En_low), 32'd0);
            last_i_low = e.i_low;
            last_flags = {e.bubble, e.over, e.under};
          end
        end else begin
          check("hold_i_low", 32'(bus.I_low), 32'(last_i_low));
          check("hold_flags", 32'({bus.bubble_err, bus.overrange, bus.underrange}),
                32'(last_flags));
          check("en_low_idle", 32'(bus.En_low), 32'd1);
        end
        check("req_dropped", 32'(bus.req_dropped), 32'(dropped_exp));
      end
    end
  end

  // Called #1 after an edge; returns #1 after the edge that brings the FSM back to IDLE.
  task automatic convert(input logic [7:0] v, input bit wait_sync, input bit drop_busy);
    exp_t e;
    bus.cmp_in = v;
    if (wait_sync) begin
      repeat (SyncStages + 1) @(posedge clk);
      #1;
    end
    e     = model(v);
    e.due = cyc + 3;
    exp_q.push_back(e);
    bus.sample_req = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_req = 1'b0;
    if (drop_busy) begin
      bus.sample_req = 1'b1;
      @(posedge clk);
      #1;
      bus.sample_req = 1'b0;
      dropped_exp    = 1'b1;
    end
    while (cyc < e.due + 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] v;
    int         lvl;
    rst            = 1'b1;
    bus.cmp_in     = 8'h0F;
    bus.sample_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    convert(8'h1F, 1'b1, 1'b0);
    convert(8'h17, 1'b1, 1'b0);
    convert(8'h00, 1'b1, 1'b0);
    convert(8'hFF, 1'b1, 1'b0);
    convert(8'h3C, 1'b1, 1'b0);

    // Busy request is dropped, then an immediate request on return to IDLE is accepted.
    convert(8'h07, 1'b1, 1'b1);
    convert(8'h07, 1'b0, 1'b0);

    // Reset while in CORRECT.
    bus.cmp_in = 8'h3F;
    repeat (SyncStages + 1) @(posedge clk);
    #1;
    bus.sample_req = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    dropped_exp = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_after_abort", 32'(bus.sample_busy), 32'd0);

    // Reset and request together: reset wins.
    rst            = 1'b1;
    bus.sample_req = 1'b1;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.sample_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_after_rst_req", 32'(bus.sample_busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom_range(0, 255));
      end else begin
        lvl = $urandom_range(0, 8);
        v   = 8'((32'h1 << lvl) - 1);
        if ($urandom_range(0, 1) == 1) v[$urandom_range(0, 7)] ^= 1'b1;
      end
      convert(v, 1'b1, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 3)) begin
        bus.cmp_in = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
